// File: rtl/usart_frame_tx_pkg.sv
// Shared constants and state encoding for the USART frame transmitter.
// Frames are a header byte, a data-byte count, then the big-endian payload.
package usart_frame_tx_pkg;

   localparam logic [7:0] HDR_FREQ = 8'h46;
   localparam logic [7:0] HDR_AMP  = 8'h4D;
   localparam logic [1:0] CNT_FREQ = 2'd3;
   localparam logic [1:0] CNT_AMP  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HEADER = 3'd1,
      ST_COUNT  = 3'd2,
      ST_DATA   = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Left-align the 12-bit multiplier so its first data byte sits in [23:16].
   function automatic logic [23:0] amp_align(input logic [11:0] mult);
      return {4'h0, mult, 8'h00};
   endfunction

endpackage

// File: rtl/usart_frame_tx_if.sv
// Byte stream toward a UART transmitter.
// Handshake: a byte transfers on every clock edge where tx_valid && tx_ready;
// once tx_valid is high, tx_data and tx_valid stay put until that transfer.
interface usart_frame_tx_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/usart_frame_tx.sv
// Frame builder: sends 'F' divider frames and 'M' multiplier frames as a byte
// stream; the payload is snapshotted on request so later input changes are harmless.
module usart_frame_tx
   import usart_frame_tx_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             send_freq,
   input  logic             send_amp,
   input  logic [23:0]      div_in,
   input  logic [11:0]      mult_in,
   output logic             busy,
   output logic             done,
   output state_t           state,
   usart_frame_tx_if.master tx
);

   logic [23:0] snap;
   logic [1:0]  cnt;
   logic        is_freq;

   // All outputs are registered; tx_ready only steers next-state, never tx_valid directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         tx.tx_valid <= 1'b0;
         tx.tx_data  <= 8'h00;
         busy        <= 1'b0;
         done        <= 1'b0;
         cnt         <= 2'd0;
         snap        <= 24'h0;
         is_freq     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (send_freq) begin
                  snap        <= div_in;
                  is_freq     <= 1'b1;
                  tx.tx_data  <= HDR_FREQ;
                  tx.tx_valid <= 1'b1;
                  busy        <= 1'b1;
                  state       <= ST_HEADER;
               end else if (send_amp) begin
                  snap        <= amp_align(mult_in);
                  is_freq     <= 1'b0;
                  tx.tx_data  <= HDR_AMP;
                  tx.tx_valid <= 1'b1;
                  busy        <= 1'b1;
                  state       <= ST_HEADER;
               end
            end

            ST_HEADER: begin
               if (tx.tx_ready) begin
                  tx.tx_data <= {6'd0, (is_freq ? CNT_FREQ : CNT_AMP)};
                  state      <= ST_COUNT;
               end
            end

            ST_COUNT: begin
               if (tx.tx_ready) begin
                  cnt        <= is_freq ? CNT_FREQ : CNT_AMP;
                  tx.tx_data <= snap[23:16];
                  snap       <= snap << 8;
                  state      <= ST_DATA;
               end
            end

            ST_DATA: begin
               if (tx.tx_ready) begin
                  if (cnt == 2'd1) begin
                     cnt         <= 2'd0;
                     tx.tx_valid <= 1'b0;
                     tx.tx_data  <= 8'h00;
                     done        <= 1'b1;
                     state       <= ST_DONE;
                  end else begin
                     cnt        <= cnt - 2'd1;
                     tx.tx_data <= snap[23:16];
                     snap       <= snap << 8;
                  end
               end
            end

            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               tx.tx_valid <= 1'b0;
               busy        <= 1'b0;
               done        <= 1'b0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usart_frame_tx.sv
// Randomized bench for usart_frame_tx: frames are predicted from the byte
// layout, collected from the handshake, and compared through one check task.
module tb_usart_frame_tx;
   import usart_frame_tx_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        send_freq;
   logic        send_amp;
   logic [23:0] div_in;
   logic [11:0] mult_in;
   logic        busy;
   logic        done;
   state_t      state;

   usart_frame_tx_if tx ();

   usart_frame_tx dut (
      .clk       (clk),
      .rst       (rst),
      .send_freq (send_freq),
      .send_amp  (send_amp),
      .div_in    (div_in),
      .mult_in   (mult_in),
      .busy      (busy),
      .done      (done),
      .state     (state),
      .tx        (tx)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         ready_mode = 0;
   int         done_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic       hold = 1'b0;
   logic [7:0] hold_data = 8'h00;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Byte collector and hold-stability monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            check("hold_valid", {31'd0, tx.tx_valid}, 32'd1);
            check("hold_data", {24'd0, tx.tx_data}, {24'd0, hold_data});
         end
         if (tx.tx_valid && tx.tx_ready) got_q.push_back(tx.tx_data);
         hold      = tx.tx_valid && !tx.tx_ready;
         hold_data = tx.tx_data;
         if (done) done_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       tx.tx_ready = 1'b1;
         1:       tx.tx_ready = ~tx.tx_ready;
         default: tx.tx_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   // Reference frame layout from the byte format, not from the RTL.
   task automatic build_frame(input bit f, input logic [23:0] d, input logic [11:0] m);
      if (f) begin
         exp_q.push_back(8'h46);
         exp_q.push_back(8'h03);
         exp_q.push_back(8'((d >> 16) & 24'hFF));
         exp_q.push_back(8'((d >> 8) & 24'hFF));
         exp_q.push_back(8'(d & 24'hFF));
      end else begin
         exp_q.push_back(8'h4D);
         exp_q.push_back(8'h02);
         exp_q.push_back(8'(m >> 8));
         exp_q.push_back(8'(m & 12'hFF));
      end
   endtask

   task automatic compare_frame();
      logic [7:0] e;
      check("nbytes", got_q.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) check("byte", {24'd0, got_q.pop_front()}, {24'd0, e});
         else check("byte_missing", 32'hDEAD, {24'd0, e});
      end
      got_q.delete();
   endtask

   task automatic run_frame(input bit f, input bit a, input logic [23:0] d,
                            input logic [11:0] m, input bit noise, input bit churn);
      int cyc;
      int nexp;
      int d0;
      send_freq = f;
      send_amp  = a;
      div_in    = d;
      mult_in   = m;
      build_frame(f, d, m);
      nexp = exp_q.size();
      d0   = done_cnt;
      step();
      send_freq = 1'b0;
      send_amp  = 1'b0;
      check("lat_valid", {31'd0, tx.tx_valid}, 32'd1);
      check("lat_hdr", {24'd0, tx.tx_data}, f ? 32'h46 : 32'h4D);
      check("busy_start", {31'd0, busy}, 32'd1);
      cyc = 0;
      while (!done && cyc < 200) begin
         if (churn) begin
            div_in  = 24'($urandom);
            mult_in = 12'($urandom);
         end
         if (noise) begin
            send_amp  = 1'($urandom_range(0, 1));
            send_freq = ($urandom_range(0, 3) == 0);
         end
         step();
         cyc++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
      check("busy_in_done", {31'd0, busy}, 32'd1);
      if (ready_mode == 0) check("frame_cycles", cyc, nexp);
      // A request landing on the DONE cycle must be dropped.
      send_freq = noise;
      send_amp  = noise;
      step();
      send_freq = 1'b0;
      send_amp  = 1'b0;
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_state", {29'd0, state}, {29'd0, ST_IDLE});
      step();
      check("no_queued", {31'd0, tx.tx_valid}, 32'd0);
      compare_frame();
      check("done_pulses", done_cnt - d0, 32'd1);
   endtask

   initial begin
      int sel;
      int d0;
      rst = 1'b1;
      send_freq = 1'b0;
      send_amp = 1'b0;
      div_in = 24'h0;
      mult_in = 12'h0;
      tx.tx_ready = 1'b0;
      ready_mode = 2;
      repeat (3) step();
      check("rst_valid", {31'd0, tx.tx_valid}, 32'd0);
      check("rst_data", {24'd0, tx.tx_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_state", {29'd0, state}, {29'd0, ST_IDLE});
      rst = 1'b0;
      repeat (2) step();
      check("idle_ready_noop", {31'd0, tx.tx_valid}, 32'd0);

      ready_mode = 0;
      run_frame(1'b1, 1'b0, 24'h123456, 12'h000, 1'b0, 1'b0);
      ready_mode = 1;
      tx.tx_ready = 1'b0;
      run_frame(1'b0, 1'b1, 24'h000000, 12'hABC, 1'b0, 1'b0);
      ready_mode = 0;
      run_frame(1'b1, 1'b1, 24'h0000FF, 12'h5A5, 1'b0, 1'b0);
      run_frame(1'b1, 1'b0, 24'h111111, 12'h000, 1'b1, 1'b1);

      // Abort an F frame after two bytes have transferred.
      ready_mode = 0;
      d0 = done_cnt;
      send_freq = 1'b1;
      div_in = 24'hC0FFEE;
      step();
      send_freq = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      check("abort_valid", {31'd0, tx.tx_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_data", {24'd0, tx.tx_data}, 32'd0);
      rst = 1'b0;
      step();
      check("abort_no_done", done_cnt - d0, 32'd0);
      check("abort_nbytes", got_q.size(), 32'd2);
      got_q.delete();
      run_frame(1'b0, 1'b1, 24'h0, 12'h3C7, 1'b0, 1'b0);

      for (int i = 0; i < 25; i++) begin
         ready_mode = $urandom_range(0, 2);
         sel = $urandom_range(0, 2);
         repeat ($urandom_range(0, 3)) begin
            step();
            check("gap_idle", {31'd0, tx.tx_valid}, 32'd0);
         end
         run_frame(sel != 1, sel != 0, 24'($urandom), 12'($urandom), 1'b1, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
